// File: rtl/sr_regfile_sb.sv
// sr_regfile_sb: XLEN x NREG register file with NRD combinational read ports,
// a debug read port, one write port, a post-reset clear sequencer and a
// per-register busy scoreboard for long-latency destinations.
// Optional feature macro: SR_RF_BYPASS_EN (write-through bypass on read ports).
module sr_regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_rdy,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    output logic                init_done
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              clr_we;
    logic              run;
    logic              wr_en;
    logic              sb_en;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]   rf_q [NREG];

    assign run       = (state_q == ST_RUN);
    assign init_done = run;
    // Entry 0 is never stored; writes and scoreboard sets to it are dropped.
    assign wr_en     = run && we && (wa != '0);
    assign sb_en     = run && sb_set && (sb_addr != '0);

    // Clear sequencer state register; reset restarts clearing at entry 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= ST_CLEAR;
            clr_cnt_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic: sweep entries 1..NREG-1, then park in RUN until reset.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Storage write: clear sweep during CLEAR, architectural write during RUN.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset port; the clear sequencer zeroes it instead.
        if (clr_we && !rst) begin
            rf_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            rf_q[wa] <= wd;
        end
    end

    // Scoreboard next state: a write retires busy, a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wa] = 1'b0;
        end
        if (sb_en) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Architectural read ports with optional write-through bypass.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = ra[g*AW +: AW];
`ifdef SR_RF_BYPASS_EN
        assign hit  = wr_en && (wa == addr);
`else
        assign hit  = 1'b0;
`endif
        assign rd[g*XLEN +: XLEN] = (addr == '0) ? '0 :
                                    hit           ? wd : rf_q[addr];
        assign rd_rdy[g] = run && ((addr == '0) || !busy_q[addr] || hit);
    end

    // Debug port reads storage only: no bypass, busy ignored.
    assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule
